tx_lanes_fifo: RTL

//  Parametrised successor to the 4-lane result transmitter. Accepts ALU results plus carry

---
 rtl/tx_lanes_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tx_lanes_fifo.sv
// Buffers ALU {carry,result} pairs in a small FIFO and serialises each one as LANES-bit beats
// on miso, advanced by rising edges of an oversampled, asynchronous spi_clk.
module tx_lanes_fifo #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_r,
  input  logic [DATA_W-1:0] res_data,
  input  logic              carry_in,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [LANES-1:0]  miso,
  output logic              carry_out,
  output logic              tx_done,
  output logic              tx_abort
);

  localparam int unsigned NBEATS  = (DATA_W + LANES - 1) / LANES;
  localparam int unsigned PAD_W   = NBEATS * LANES;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [ENTRY_W-1:0] head;
  logic               push, pop;

  logic [1:0]         spi_sync_q;
  logic               spi_prev_q;
  logic               rise;

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   shift_q, shift_d;
  logic               carry_q, carry_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               abort_q, abort_d;
  logic [BEAT_W-1:0]  beat_sel;
  logic [PAD_W-1:0]   shifted;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign res_ready = rst_n && (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = res_valid && res_ready;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {carry_in, res_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // spi_clk is asynchronous to clk; rise is a one-cycle pulse after the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_sync_q <= '0;
      spi_prev_q <= 1'b0;
    end else begin
      spi_sync_q <= {spi_sync_q[0], spi_clk};
      spi_prev_q <= spi_sync_q[1];
    end
  end

  assign rise = spi_sync_q[1] & ~spi_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      carry_q <= 1'b0;
      beat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      beat_q  <= beat_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    carry_d = carry_q;
    beat_d  = beat_q;
    abort_d = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (spi_r && (count_q != '0)) begin
          pop     = 1'b1;
          shift_d = PAD_W'(head[DATA_W-1:0]);
          carry_d = head[DATA_W];
          beat_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Abort takes priority over a rise in the same cycle.
        if (!spi_r) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (rise) begin
          if (beat_q == BEAT_W'(NBEATS - 1)) state_d = StDone;
          else                               beat_d  = beat_q + BEAT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign beat_sel  = MSB_FIRST ? (BEAT_W'(NBEATS - 1) - beat_q) : beat_q;
  assign shifted   = shift_q >> (beat_sel * LANES);
  assign miso      = (state_q == StShift) ? shifted[LANES-1:0] : '0;
  assign carry_out = (state_q == StShift) && carry_q;
  assign tx_done   = (state_q == StDone);
  assign tx_abort  = abort_q;

endmodule
